sr_driver: RTL and testbench

Command-side companion to the team's SR flip-flop: accepts "drive channel i to value v" requests over a valid/ready handshake and generates the excitation pulses (s or r) for a bank of SR flip-flops. It never asserts s and r together, and skips pulses when a channel already holds the requested value. With checking compiled in, it reads back each flop's q and reports mismatches. It sits between control logic and the SR storage bank.

---
 rtl/sr_pkg.sv | 21 ++
 rtl/sr_pulse_timer.sv | 29 ++
 rtl/sr_driver.sv | 168 ++++++++++++++++
 tb/tb_sr_driver.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared types and limits for the SR flop excitation driver.
// The optional q readback check in sr_driver is enabled by defining SR_DRIVER_CHECK_EN.
package sr_pkg;

    localparam int SR_MAX_CHANNELS = 16;
    localparam int SR_IDX_MAX_W    = $clog2(SR_MAX_CHANNELS);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        SETTLE,
        RESP
    } sr_state_t;

    // Drive command: target channel and the level to leave it at.
    typedef struct packed {
        logic [SR_IDX_MAX_W-1:0] index;
        logic                    value;
    } sr_cmd_t;

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter that times the s/r pulse width of sr_driver.
// done is high while the count sits at 1, i.e. during the last pulse cycle.
module sr_pulse_timer #(
    parameter int PULSE_LEN = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int CNT_W = $clog2(PULSE_LEN + 1);

    logic [CNT_W-1:0] count;

    // Load the full pulse width, then count down and park at zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(PULSE_LEN);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign done = (count == CNT_W'(1));

endmodule

// File: rtl/sr_driver.sv
// Request-driven pulse generator for a bank of SR flip-flops.
// Pulses are suppressed when the shadow copy says the channel already holds
// the requested level. Define SR_DRIVER_CHECK_EN to compare q in the response
// cycle; otherwise q is ignored and only a bad index raises resp_error.
module sr_driver
    import sr_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int PULSE_LEN = 1,
    parameter int IDX_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [IDX_W-1:0]    req_index,
    input  logic                req_value,
    output logic [CHANNELS-1:0] s,
    output logic [CHANNELS-1:0] r,
    input  logic [CHANNELS-1:0] q,
    output logic                resp_valid,
    output logic                resp_error,
    output logic                resp_skipped
);

    sr_state_t           state, state_d;
    sr_cmd_t             cmd_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CHANNELS-1:0] shadow, shadow_valid;
    logic [CHANNELS-1:0] req_onehot, cmd_onehot;
    logic [CHANNELS-1:0] s_p0, r_p0;
    logic                rv_p0, err_p0, skp_p0;
    logic                rv_p1, err_p1, skp_p1;
    logic                accept, timer_load, timer_done;
    logic                bad_index, already_set, mismatch;
    logic                unused_cmd;

    assign idx_q       = cmd_q.index[IDX_W-1:0];
    assign unused_cmd  = ^cmd_q;
    assign req_onehot  = CHANNELS'(1) << req_index;
    assign cmd_onehot  = CHANNELS'(1) << idx_q;
    assign bad_index   = (32'(req_index) >= CHANNELS);
    assign already_set = shadow_valid[req_index] && (shadow[req_index] == req_value);
    assign req_ready   = (state == IDLE);

`ifdef SR_DRIVER_CHECK_EN
    // Readback happens in RESP, two edges after the last pulse, so q has settled.
    assign mismatch = (state == RESP) && !skp_p1 && (q[idx_q] != cmd_q.value);
`else
    logic unused_q;
    assign unused_q = ^q;
    assign mismatch = 1'b0;
`endif

    assign resp_valid   = rv_p1;
    assign resp_skipped = skp_p1;
    assign resp_error   = err_p1 | mismatch;

    sr_pulse_timer #(
        .PULSE_LEN (PULSE_LEN)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .load  (timer_load),
        .done  (timer_done)
    );

    // Next state plus next values of the registered pulse and response outputs.
    always_comb begin
        state_d    = state;
        s_p0       = '0;
        r_p0       = '0;
        rv_p0      = 1'b0;
        err_p0     = 1'b0;
        skp_p0     = 1'b0;
        timer_load = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (bad_index) begin
                        state_d = RESP;
                        rv_p0   = 1'b1;
                        err_p0  = 1'b1;
                        skp_p0  = 1'b1;
                    end else if (already_set) begin
                        state_d = RESP;
                        rv_p0   = 1'b1;
                        skp_p0  = 1'b1;
                    end else begin
                        state_d    = PULSE;
                        timer_load = 1'b1;
                        s_p0       = req_value ? req_onehot : '0;
                        r_p0       = req_value ? '0 : req_onehot;
                    end
                end
            end
            PULSE: begin
                if (timer_done) begin
                    state_d = SETTLE;
                end else begin
                    s_p0 = cmd_q.value ? cmd_onehot : '0;
                    r_p0 = cmd_q.value ? '0 : cmd_onehot;
                end
            end
            SETTLE: begin
                state_d = RESP;
                rv_p0   = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Registered excitation pulses and response strobes; reset drops s/r at once.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s      <= '0;
            r      <= '0;
            rv_p1  <= 1'b0;
            err_p1 <= 1'b0;
            skp_p1 <= 1'b0;
        end else begin
            s      <= s_p0;
            r      <= r_p0;
            rv_p1  <= rv_p0;
            err_p1 <= err_p0;
            skp_p1 <= skp_p0;
        end
    end

    // Shadow of each flop's level, committed when a pulsed request completes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shadow       <= '0;
            shadow_valid <= '0;
        end else if ((state == RESP) && !skp_p1) begin
            if (mismatch) begin
                shadow_valid[idx_q] <= 1'b0;
            end else begin
                shadow[idx_q]       <= cmd_q.value;
                shadow_valid[idx_q] <= 1'b1;
            end
        end
    end

    // Latch the accepted command; it is only read while the request is in flight.
    always_ff @(posedge clock) begin
        if (accept) begin
            cmd_q <= '{index: SR_IDX_MAX_W'(req_index), value: req_value};
        end
    end

endmodule

// File: tb/tb_sr_driver.sv
// Bench for sr_driver: instance A (4 channels, 1-cycle pulse) and instance B
// (3 channels, 3-cycle pulse) share the request bus, selected by sel.
module tb_sr_driver;

    localparam int A_CH = 4;
    localparam int A_PL = 1;
    localparam int B_CH = 3;
    localparam int B_PL = 3;
`ifdef SR_DRIVER_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst_a, rst_b, req_valid, req_value, sel;
    logic [1:0] req_index;
    logic       va, vb;
    logic [3:0] s_a, r_a, qa, hold_mask, hold_val;
    logic [3:0] core_a = '0;
    logic [2:0] s_b, r_b, qb;
    logic [2:0] core_b = '0;
    logic       rdy_a, rv_a, er_a, sk_a, rdy_b, rv_b, er_b, sk_b;

    int checks   = 0;
    int failures = 0;
    bit sh [2][4];
    bit sv [2][4];

    assign va = req_valid & ~sel;
    assign vb = req_valid & sel;
    assign qa = (core_a & ~hold_mask) | (hold_val & hold_mask);
    assign qb = core_b;

    wire [3:0] o_s   = sel ? {1'b0, s_b} : s_a;
    wire [3:0] o_r   = sel ? {1'b0, r_b} : r_a;
    wire       o_rdy = sel ? rdy_b : rdy_a;
    wire       o_rv  = sel ? rv_b : rv_a;
    wire       o_er  = sel ? er_b : er_a;
    wire       o_sk  = sel ? sk_b : sk_a;

    sr_driver #(.CHANNELS(A_CH), .PULSE_LEN(A_PL)) dut_a (
        .clock(clock), .reset(rst_a), .req_valid(va), .req_ready(rdy_a),
        .req_index(req_index), .req_value(req_value), .s(s_a), .r(r_a), .q(qa),
        .resp_valid(rv_a), .resp_error(er_a), .resp_skipped(sk_a)
    );

    sr_driver #(.CHANNELS(B_CH), .PULSE_LEN(B_PL)) dut_b (
        .clock(clock), .reset(rst_b), .req_valid(vb), .req_ready(rdy_b),
        .req_index(req_index), .req_value(req_value), .s(s_b), .r(r_b), .q(qb),
        .resp_valid(rv_b), .resp_error(er_b), .resp_skipped(sk_b)
    );

    // Behavioural SR flop banks driven by the DUT pulses.
    always @(posedge clock) begin
        core_a <= (core_a | s_a) & ~r_a;
        core_b <= (core_b | s_b) & ~r_b;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Excitation invariants on both instances every cycle.
    always @(negedge clock) begin
        checks++;
        assert (((s_a & r_a) == 4'b0) && ($countones(s_a | r_a) <= 1)) else begin
            failures++;
            $error("FAIL inv_a observed s=%b r=%b expected disjoint and at most one bit", s_a, r_a);
        end
        checks++;
        assert (((s_b & r_b) == 3'b0) && ($countones(s_b | r_b) <= 1)) else begin
            failures++;
            $error("FAIL inv_b observed s=%b r=%b expected disjoint and at most one bit", s_b, r_b);
        end
    end

    // One request on the selected instance, checked against the rules for
    // bad index, skip and pulse, then the reference shadow is updated.
    task automatic run_req(input int idx, input bit val, input string tag);
        int   ch, pl, lat, pulses;
        bit   bad, skip, badpat, mis;
        logic [3:0] oh;
        logic got_er, got_sk;
        ch   = sel ? B_CH : A_CH;
        pl   = sel ? B_PL : A_PL;
        bad  = (idx >= ch);
        skip = !bad && sv[sel][idx] && (sh[sel][idx] == val);
        mis  = CHECK_EN && !sel && hold_mask[idx] && (hold_val[idx] != val);
        oh   = 4'b0001 << idx;
        @(negedge clock);
        chk({tag, "_ready"}, 32'(o_rdy), 32'd1);
        req_index = 2'(idx);
        req_value = val;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        lat    = -1;
        pulses = 0;
        badpat = 1'b0;
        got_er = 1'bx;
        got_sk = 1'bx;
        for (int n = 0; n < 20; n++) begin
            if ((o_s | o_r) != 4'b0) begin
                if (n != pulses) badpat = 1'b1;
                if (val ? (o_s != oh || o_r != 4'b0) : (o_r != oh || o_s != 4'b0)) badpat = 1'b1;
                pulses++;
            end
            if (o_rv === 1'b1) begin
                lat    = n;
                got_er = o_er;
                got_sk = o_sk;
                break;
            end
            @(negedge clock);
        end
        chk({tag, "_pattern_bad"}, 32'(badpat), 32'd0);
        if (bad || skip) begin
            chk({tag, "_latency"}, 32'(lat), 32'd0);
            chk({tag, "_pulses"}, 32'(pulses), 32'd0);
            chk({tag, "_error"}, 32'(got_er), 32'(bad));
            chk({tag, "_skipped"}, 32'(got_sk), 32'd1);
        end else begin
            chk({tag, "_latency"}, 32'(lat), 32'(pl + 1));
            chk({tag, "_pulses"}, 32'(pulses), 32'(pl));
            chk({tag, "_error"}, 32'(got_er), 32'(mis));
            chk({tag, "_skipped"}, 32'(got_sk), 32'd0);
            if (mis) begin
                sv[sel][idx] = 1'b0;
            end else begin
                sh[sel][idx] = val;
                sv[sel][idx] = 1'b1;
            end
        end
    endtask

    initial begin
        int idx;
        bit val;
        rst_a = 1'b0; rst_b = 1'b0; req_valid = 1'b0; req_value = 1'b0;
        req_index = '0; sel = 1'b0; hold_mask = '0; hold_val = '0;
        repeat (3) @(negedge clock);
        chk("in_reset_s", 32'(s_a), 32'd0);
        chk("in_reset_rv", 32'(rv_a), 32'd0);
        rst_a = 1'b1;
        rst_b = 1'b1;
        @(negedge clock);
        chk("reset_ready_a", 32'(rdy_a), 32'd1);
        chk("reset_s_a", 32'(s_a), 32'd0);
        chk("reset_r_a", 32'(r_a), 32'd0);
        chk("reset_rv_a", 32'(rv_a), 32'd0);
        chk("reset_err_a", 32'(er_a), 32'd0);
        chk("reset_skp_a", 32'(sk_a), 32'd0);
        chk("reset_ready_b", 32'(rdy_b), 32'd1);

        sel = 1'b0;
        run_req(2, 1'b1, "pulse_2_1");
        run_req(2, 1'b1, "skip_2_1");
        run_req(2, 1'b0, "pulse_2_0");
        sel = 1'b1;
        run_req(3, 1'b1, "bad_idx3");

        sel = 1'b0;
        hold_mask = 4'b0010;
        hold_val  = 4'b0000;
        run_req(1, 1'b1, "hold_q1");
        run_req(1, 1'b1, "hold_q1_repeat");
        @(posedge clock);
        #1 hold_mask = '0;

        // Reset instance B during its second pulse cycle.
        sel = 1'b1;
        @(negedge clock);
        req_index = 2'd0;
        req_value = 1'b1;
        req_valid = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        chk("midrst_pulse1", 32'(o_s), 32'd1);
        @(negedge clock);
        chk("midrst_pulse2", 32'(o_s), 32'd1);
        rst_b = 1'b0;
        #1;
        chk("midrst_s_drop", 32'(o_s), 32'd0);
        chk("midrst_r_drop", 32'(o_r), 32'd0);
        chk("midrst_no_resp", 32'(o_rv), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("midrst_hold_no_resp", 32'(o_rv), 32'd0);
        end
        rst_b = 1'b1;
        for (int i = 0; i < 4; i++) sv[1][i] = 1'b0;
        @(negedge clock);
        chk("midrst_ready", 32'(o_rdy), 32'd1);
        chk("midrst_s_idle", 32'(o_s), 32'd0);
        run_req(0, 1'b1, "after_midrst");

        for (int i = 0; i < 40; i++) begin
            sel = 1'($urandom_range(0, 1));
            idx = int'($urandom_range(0, 3));
            val = 1'($urandom_range(0, 1));
            if (!sel && ($urandom_range(0, 3) == 0)) begin
                hold_mask = 4'b0001 << idx;
                hold_val  = 4'($urandom_range(0, 15));
            end
            run_req(idx, val, "rand");
            @(posedge clock);
            #1 hold_mask = '0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
